// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader: FSM states, error codes,
// stream/word widths and a byte-sum helper used by the read-back check.
package loader_pkg;

    localparam int BYTE_W         = 8;
    localparam int WORD_W         = 32;
    localparam int BYTES_PER_WORD = WORD_W / BYTE_W;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_DATA,
        ST_WRITE,
        ST_CHECK,
        ST_VERIFY,
        ST_DONE,
        ST_ERROR
    } loaderState_e;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_LEN     = 2'd1;
    localparam logic [1:0] ERR_CSUM    = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    // Mod-256 sum of the four bytes of a word, matching the frame checksum rule.
    function automatic logic [BYTE_W-1:0] byteSum(input logic [WORD_W-1:0] w);
        return w[31:24] + w[23:16] + w[15:8] + w[7:0];
    endfunction

endpackage

// File: rtl/loader_word_assembler.sv
// Big-endian byte-to-word assembler: shifts bytes in MSB first and flags the
// byte that completes a word.
module loader_word_assembler
    import loader_pkg::*;
(
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              clear_i,
    input  logic              shiftEn_i,
    input  logic [BYTE_W-1:0] byte_i,
    output logic [WORD_W-1:0] word_o,
    output logic              wordFull_o
);

    logic [1:0]        count_q, count_d;
    logic [WORD_W-1:0] shift_q, shift_d;

    always_comb begin
        count_d = count_q;
        shift_d = shift_q;
        if (clear_i) begin
            count_d = 2'd0;
            shift_d = '0;
        end else if (shiftEn_i) begin
            count_d = count_q + 2'd1;
            shift_d = {shift_q[WORD_W-BYTE_W-1:0], byte_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= 2'd0;
            shift_q <= '0;
        end else begin
            count_q <= count_d;
            shift_q <= shift_d;
        end
    end

    // Pulses with the 4th byte; the full word is visible from the next cycle.
    assign word_o     = shift_q;
    assign wordFull_o = shiftEn_i && (count_q == 2'd3);

endmodule

// File: rtl/program_loader.sv
// Loads a framed byte stream (length, big-endian words, checksum) into memory.
// Define LOADER_VERIFY_EN to add a read-back pass that re-checks the checksum.
module program_loader
    import loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'h0,
    parameter int          MAX_WORDS      = 256,
    parameter int          TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic [31:0] Address,
    output logic [31:0] Write_data,
    output logic        MemRead,
    output logic        MemWrite,
    input  logic [31:0] Mem_data,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [1:0]  error_code
);

    loaderState_e state_q, state_d;
    logic [15:0]  len_q, len_d;
    logic [15:0]  idx_q, idx_d;
    logic [7:0]   sum_q, sum_d;
    logic [31:0]  timer_q, timer_d;
    logic         done_q, done_d;
    logic         error_q, error_d;
    logic [1:0]   errCode_q, errCode_d;

    logic         accept;
    logic         restart;
    logic         timeoutHit;
    logic [15:0]  lenFull;
    logic [31:0]  word;
    logic         wordFull;

`ifdef LOADER_VERIFY_EN
    logic [7:0]   verifySum_q, verifySum_d;
`else
    logic         unusedMemData;
    assign unusedMemData = ^Mem_data;
`endif

    assign byte_ready = (state_q == ST_LEN_HI) || (state_q == ST_LEN_LO) ||
                        (state_q == ST_DATA)   || (state_q == ST_CHECK);
    assign accept     = byte_valid && byte_ready;
    assign restart    = start && ((state_q == ST_IDLE) || (state_q == ST_DONE) ||
                                  (state_q == ST_ERROR));
    assign lenFull    = {len_q[15:8], byte_in};

    loader_word_assembler u_assembler (
        .clk_i      (clk),
        .reset_i    (reset),
        .clear_i    (restart),
        .shiftEn_i  (accept && (state_q == ST_DATA)),
        .byte_i     (byte_in),
        .word_o     (word),
        .wordFull_o (wordFull)
    );

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        idx_d      = idx_q;
        sum_d      = sum_q;
        timer_d    = timer_q;
        done_d     = done_q;
        error_d    = error_q;
        errCode_d  = errCode_q;
        timeoutHit = 1'b0;
        MemWrite   = 1'b0;
        MemRead    = 1'b0;
        Address    = BASE_ADDR;
        Write_data = '0;
`ifdef LOADER_VERIFY_EN
        verifySum_d = verifySum_q;
`endif

        // The idle counter only runs while waiting on the stream; WRITE holds it.
        if (byte_ready) begin
            if (accept) begin
                timer_d = '0;
            end else if (TIMEOUT_CYCLES != 0) begin
                timer_d    = timer_q + 32'd1;
                timeoutHit = (timer_d == 32'(TIMEOUT_CYCLES));
            end
        end

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    state_d   = ST_LEN_HI;
                    done_d    = 1'b0;
                    error_d   = 1'b0;
                    errCode_d = ERR_NONE;
                    idx_d     = '0;
                    sum_d     = '0;
                    timer_d   = '0;
                end
            end
            ST_LEN_HI: begin
                if (accept) begin
                    len_d   = {byte_in, len_q[7:0]};
                    state_d = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (accept) begin
                    len_d = lenFull;
                    if (32'(lenFull) > 32'(MAX_WORDS)) begin
                        state_d   = ST_ERROR;
                        error_d   = 1'b1;
                        errCode_d = ERR_LEN;
                    end else if (lenFull == 16'd0) begin
                        state_d = ST_CHECK;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (accept) begin
                    sum_d = sum_q + byte_in;
                    if (wordFull) begin
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                MemWrite   = 1'b1;
                Address    = BASE_ADDR + {14'd0, idx_q, 2'b00};
                Write_data = word;
                idx_d      = idx_q + 16'd1;
                state_d    = (idx_d == len_q) ? ST_CHECK : ST_DATA;
            end
            ST_CHECK: begin
                if (accept) begin
                    if (byte_in != sum_q) begin
                        state_d   = ST_ERROR;
                        error_d   = 1'b1;
                        errCode_d = ERR_CSUM;
                    end else begin
`ifdef LOADER_VERIFY_EN
                        state_d     = ST_VERIFY;
                        idx_d       = '0;
                        verifySum_d = '0;
`else
                        state_d = ST_DONE;
                        done_d  = 1'b1;
`endif
                    end
                end
            end
`ifdef LOADER_VERIFY_EN
            // One read per word, then a single compare cycle against the stream sum.
            ST_VERIFY: begin
                if (idx_q != len_q) begin
                    MemRead     = 1'b1;
                    Address     = BASE_ADDR + {14'd0, idx_q, 2'b00};
                    verifySum_d = verifySum_q + byteSum(Mem_data);
                    idx_d       = idx_q + 16'd1;
                end else if (verifySum_q == sum_q) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d   = ST_ERROR;
                    error_d   = 1'b1;
                    errCode_d = ERR_CSUM;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (timeoutHit) begin
            state_d   = ST_ERROR;
            error_d   = 1'b1;
            errCode_d = ERR_TIMEOUT;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            len_q     <= '0;
            idx_q     <= '0;
            sum_q     <= '0;
            timer_q   <= '0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            errCode_q <= ERR_NONE;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            sum_q     <= sum_d;
            timer_q   <= timer_d;
            done_q    <= done_d;
            error_q   <= error_d;
            errCode_q <= errCode_d;
        end
    end

`ifdef LOADER_VERIFY_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            verifySum_q <= '0;
        end else begin
            verifySum_q <= verifySum_d;
        end
    end
`endif

    assign busy       = !((state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERROR));
    assign done       = done_q;
    assign error      = error_q;
    assign error_code = errCode_q;

endmodule
